mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter onto a single-port RAM: writes take one cycle, reads
// hold the bus for one extra cycle while the RAM returns data.
module mem_bus_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned MW = 4;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;  // 0 = m0, 1 = m1
    logic            owner;       // master whose read is in flight
    logic            grant_any;
    logic            winner;
    logic [MW-1:0]   win_wmask;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Arbitration, grant and RAM strobes; everything is forced quiet in reset
    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        winner    = 1'b0;
        win_wmask = '0;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_rstrb = 1'b0;
        mem_wmask = '0;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        if (resetn) begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant_any = 1'b1;
                        if (m0_req && m1_req) winner = FIXED_PRIO ? 1'b0 : ~last_grant;
                        else                  winner = m1_req;
                        m0_gnt    = ~winner;
                        m1_gnt    = winner;
                        mem_addr  = winner ? m1_addr  : m0_addr;
                        mem_wdata = winner ? m1_wdata : m0_wdata;
                        win_wmask = winner ? m1_wmask : m0_wmask;
                        if (win_wmask == '0) begin
                            mem_rstrb = 1'b1;
                            state_nxt = RD_WAIT;
                        end else begin
                            mem_wmask = win_wmask;
                        end
                    end
                end
                RD_WAIT: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Grant history, read ownership and per-master read-data capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (grant_any) last_grant <= winner;
            if (mem_rstrb) owner <= winner;
            if (state == RD_WAIT) begin
                if (owner) begin
                    m1_rdata  <= mem_rdata;
                    m1_rvalid <= 1'b1;
                end else begin
                    m0_rdata  <= mem_rdata;
                    m0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
